// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display
//  Description : Four-digit multiplexed common-anode seven-segment driver.
//                Snapshots the BCD mm:ss digits once per frame, scans them
//                right to left, and optionally blinks the field picked by
//                sel while adjust mode is active.
//                Optional blink logic: define STOPWATCH_DISP_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int            RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic          valid;
  logic [15:0]   snap;
  logic          ref_tc;
  logic          frame_wrap;
  logic [3:0]    blank_mask;
  logic [3:0]    digit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign ref_tc     = (refresh_cnt == REF_LAST);
  assign frame_wrap = ref_tc && (idx == 2'd3);

  // Scan timing; it only starts once the first snapshot exists so that the
  // rightmost digit gets its full dwell time after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
    end else if (valid) begin
      if (ref_tc) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
    end
  end

  // Capture all four digits together so a frame never mixes two counter values.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap  <= 16'h0000;
      valid <= 1'b0;
    end else if (!valid || frame_wrap) begin
      snap  <= {min_tens, min_ones, sec_tens, sec_ones};
      valid <= 1'b1;
    end
  end

`ifdef STOPWATCH_DISP_BLINK_EN
  localparam int            BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Blink phase generator; parked in the visible phase whenever adjust is off.
  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank_mask = (adj && !blink_on) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
`else
  logic unused_adj_sel;
  assign unused_adj_sel = adj ^ sel;
  assign blank_mask     = 4'b0000;
`endif

  // Active-low segment pattern for one BCD digit; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Select the digit for the current index and form the next pin values.
  always_comb begin
    digit    = snap[3:0];
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    case (idx)
      2'd0:    digit = snap[3:0];
      2'd1:    digit = snap[7:4];
      2'd2:    digit = snap[11:8];
      default: digit = snap[15:12];
    endcase
    if (valid) begin
      an_next  = ~(4'b0001 << idx) | blank_mask;
      seg_next = decode(digit);
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_display
//  Description : Self-checking bench for stopwatch_display with a frame/time
//                based reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display;

  localparam int R = 4;
  localparam int B = 16;
`ifdef STOPWATCH_DISP_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min_tens = 4'd0;
  logic [3:0] min_ones = 4'd0;
  logic [3:0] sec_tens = 4'd0;
  logic [3:0] sec_ones = 4'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  int errors = 0;
  int checks = 0;

  stopwatch_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .adj(adj), .sel(sel), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          mk = 0;       // edges since reset release
  int          ma = 0;       // consecutive non-reset edges with adj high
  logic [15:0] snap_m = 16'h0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic [6:0]  seg_tbl [0:9];

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    if (v > 4'd9) return 7'b0111111;
    return seg_tbl[v];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs,
  // then move to the following falling edge where outputs are compared.
  task automatic tick();
    int d;
    logic [3:0] dig;
    if (rst) begin
      mk = 0; ma = 0;
      exp_an = 4'hF; exp_seg = 7'h7F;
    end else begin
      mk = mk + 1;
      if (mk == 1) begin
        exp_an = 4'hF; exp_seg = 7'h7F;
      end else begin
        d = ((mk - 2) / R) % 4;
        dig = snap_m[4*d +: 4];
        exp_an = 4'hF;
        exp_an[d] = 1'b0;
        exp_seg = ref_seg(dig);
        if (BLINK_EN && adj && (((ma / B) % 2) == 1))
          exp_an = exp_an | (sel ? 4'b0011 : 4'b1100);
      end
      if (((mk - 1) % (4 * R)) == 0) snap_m = {min_tens, min_ones, sec_tens, sec_ones};
      ma = adj ? ma + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; adj = 1'b0; sel = 1'b0;
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    repeat (3) begin
      tick();
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111) begin
        errors++;
        $display("FAIL reset_hold: an=%b seg=%b required an=1111 seg=1111111", an, seg);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL reset_edge1: an=%b required 1111", an);
    end
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0011001) begin
      errors++;
      $display("FAIL reset_edge2: an=%b seg=%b required an=1110 seg=0011001", an, seg);
    end
    repeat (16) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL reset_scan: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL midframe_wait: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
      if (exp_an == 4'b1101) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_index1: not reached within 20 cycles, required reached");
    end
    sec_ones = 4'd5;
    repeat (2 * 4 * R + 4) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL midframe_change: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_bcd_range();
    bit seen_dash = 1'b0;
    min_ones = 4'hC;
    repeat (2 * 4 * R + 2) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL bcd_range: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
      if (an == 4'b1011 && seg == 7'b0111111) seen_dash = 1'b1;
    end
    checks++;
    if (!seen_dash) begin
      errors++;
      $display("FAIL bcd_dash: seen=%0d required 1", seen_dash);
    end
  endtask

  task automatic test_blink();
    adj = 1'b1; sel = 1'b1;
    repeat (80) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL blink_run: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end
    adj = 1'b0;
    tick();
    checks++;
    if ($countones(~an) != 1 || an !== exp_an) begin
      errors++;
      $display("FAIL blink_drop: an=%b required %b", an, exp_an);
    end
  endtask

  task automatic test_reset_mid_blink();
    adj = 1'b1; sel = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL rstblink_run: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
      if (exp_an == 4'b1111 && i > 20) break;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111) begin
      errors++;
      $display("FAIL rstblink_assert: an=%b seg=%b required an=1111 seg=1111111", an, seg);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL rstblink_edge1: an=%b required 1111", an);
    end
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== ref_seg(sec_ones)) begin
      errors++;
      $display("FAIL rstblink_edge2: an=%b seg=%b required an=1110 seg=%b", an, seg, ref_seg(sec_ones));
    end
    repeat (20) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL rstblink_after: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_adjust_minutes();
    adj = 1'b1; sel = 1'b0;
    repeat (64) begin
      tick();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL adj_minutes: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end
    adj = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      min_tens = 4'($urandom_range(0, 15));
      min_ones = 4'($urandom_range(0, 15));
      sec_tens = 4'($urandom_range(0, 15));
      sec_ones = 4'($urandom_range(0, 15));
      adj = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(5, 50)) begin
        tick();
        rst = 1'b0;
        checks++;
        if (an !== exp_an || seg !== exp_seg) begin
          errors++;
          $display("FAIL random: an=%b seg=%b required an=%b seg=%b", an, seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
    seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
    seg_tbl[9] = 7'b0010000;
    @(negedge clk);
    test_reset();
    test_mid_frame_change();
    test_bcd_range();
    test_blink();
    test_reset_mid_blink();
    test_adjust_minutes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
